// File: rtl/sync_edge_monitor.sv
// sync_edge_monitor: edge detect/count plus rise-to-rise period records with stall.
// Define SYNC_MON_FALL_EN to build falling-edge detection and counting.
module sync_edge_monitor #(
  parameter int PERIOD_W = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk_B,
  input  logic                reset_B,
  input  logic                sync_in,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [7:0]          edge_count,
  output logic                period_valid,
  input  logic                period_ready,
  output logic [PERIOD_W-1:0] period_data,
  output logic                stall,
  output logic                overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MEAS  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [PERIOD_W-1:0] LP_TO = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] LP_ONE = PERIOD_W'(1);

  logic                r_sync_q;
  logic                r_rise;
  logic [7:0]          r_ecnt;
  logic [1:0]          r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_stall;
  logic                r_valid;
  logic [PERIOD_W-1:0] r_data;
  logic                r_ovr;

  logic w_rise;
  logic w_edge;
  logic w_new_rec;

  assign w_rise = sync_in & ~r_sync_q;

`ifdef SYNC_MON_FALL_EN
  logic r_fall;
  logic w_fall;

  assign w_fall = ~sync_in & r_sync_q;
  assign w_edge = w_rise | w_fall;
  assign fall_pulse = r_fall;

  always_ff @(posedge clk_B) begin
    if (reset_B) r_fall <= 1'b0;
    else         r_fall <= w_fall;
  end
`else
  assign w_edge = w_rise;
  assign fall_pulse = 1'b0;
`endif

  // Only a rise that closes a valid interval yields a record.
  assign w_new_rec = (r_state == S_MEAS) && w_rise;

  always_ff @(posedge clk_B) begin
    if (reset_B) begin
      r_sync_q <= 1'b0;
      r_rise   <= 1'b0;
      r_ecnt   <= 8'd0;
    end else begin
      r_sync_q <= sync_in;
      r_rise   <= w_rise;
      if (w_edge) r_ecnt <= r_ecnt + 8'd1;
    end
  end

  always_ff @(posedge clk_B) begin
    if (reset_B) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_MEAS;
            r_cnt   <= LP_ONE;
          end
        end
        S_MEAS: begin
          if (w_rise) begin
            r_cnt <= LP_ONE;
          end else if (r_cnt == LP_TO) begin
            r_state <= S_STALL;
            r_stall <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        S_STALL: begin
          if (w_rise) begin
            r_state <= S_MEAS;
            r_cnt   <= LP_ONE;
            r_stall <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_B) begin
    if (reset_B) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else if (w_new_rec) begin
      if (!r_valid || period_ready) begin
        r_data  <= r_cnt;
        r_valid <= 1'b1;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && period_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rise_pulse   = r_rise;
  assign edge_count   = r_ecnt;
  assign period_valid = r_valid;
  assign period_data  = r_data;
  assign stall        = r_stall;
  assign overrun      = r_ovr;

endmodule
